// File: rtl/block_memory_if.sv
// Cache-to-memory block request bus: level read/write request, combinational busywait answer.
// Master is the cache miss/write-back FSM, slave is block_memory.
interface block_memory_if #(
    parameter int ADDR_W = 28
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [127:0]      writedata;
    logic [127:0]      readdata;
    logic              busywait;

    modport master (
        output read, write, address, writedata,
        input  readdata, busywait
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, busywait
    );
endinterface

// File: rtl/block_memory.sv
// Block-granular backing memory behind the data cache (128-bit blocks, DEPTH entries).
// Latency: busywait falls LATENCY+1 edges after the request; one-cycle DONE bubble before the next accept.
// Backpressure: combinational busywait holds the requester; BLOCK_MEMORY_PERF_EN adds rd_count/wr_count.
module block_memory #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 5,
    parameter int ADDR_W  = 28
) (
    input  logic               clock,
    input  logic               reset,
    block_memory_if.slave      bus
`ifdef BLOCK_MEMORY_PERF_EN
    ,
    output logic [31:0]        rd_count,
    output logic [31:0]        wr_count
`endif
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             state;
    logic [7:0]         counter;
    logic [IDX_W-1:0]   lat_idx;
    logic [127:0]       lat_data;
    logic               lat_wr;
    logic [127:0]       mem [DEPTH];

    // Upper block-address bits alias onto the same index.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.address[ADDR_W-1:IDX_W];

    // Busywait must rise in the request cycle itself, so the IDLE term is combinational.
    always_comb begin
        bus.busywait = 1'b0;
        case (state)
            IDLE:    bus.busywait = bus.read | bus.write;
            ACCESS:  bus.busywait = 1'b1;
            default: bus.busywait = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            counter      <= '0;
            lat_idx      <= '0;
            lat_data     <= '0;
            lat_wr       <= 1'b0;
            bus.readdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
`ifdef BLOCK_MEMORY_PERF_EN
            rd_count     <= '0;
            wr_count     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.read | bus.write) begin
                        lat_idx  <= bus.address[IDX_W-1:0];
                        lat_data <= bus.writedata;
                        // read & write together resolves to a write.
                        lat_wr   <= bus.write;
                        counter  <= 8'(LATENCY - 1);
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (counter == 8'd0) begin
                        if (lat_wr) begin
                            mem[lat_idx] <= lat_data;
`ifdef BLOCK_MEMORY_PERF_EN
                            wr_count     <= wr_count + 32'd1;
`endif
                        end else begin
                            bus.readdata <= mem[lat_idx];
`ifdef BLOCK_MEMORY_PERF_EN
                            rd_count     <= rd_count + 32'd1;
`endif
                        end
                        state <= DONE;
                    end else begin
                        counter <= counter - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_block_memory.sv
// Directed bench for block_memory: latency, data integrity, aliasing, back-to-back, reset abort.
module tb_block_memory;
    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] D1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] D2 = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] D3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] D4 = 128'h00000001_00000002_00000003_00000004;
    localparam logic [127:0] D5 = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;
    localparam logic [127:0] D6 = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;

    always #5 clock = ~clock;

    block_memory_if #(.ADDR_W(28)) bus ();

`ifdef BLOCK_MEMORY_PERF_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    block_memory #(.DEPTH(256), .LATENCY(5), .ADDR_W(28)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus)
`ifdef BLOCK_MEMORY_PERF_EN
        ,
        .rd_count (rd_count),
        .wr_count (wr_count)
`endif
    );

    task automatic to_idle;
        @(posedge clock);
        #1;
    endtask

    // Presents a request at posedge+1 and returns in the DONE cycle with the request dropped.
    task automatic access(input logic rd, input logic wr, input logic [27:0] a,
                          input logic [127:0] d, output int edges, output logic bw0);
        bus.read      = rd;
        bus.write     = wr;
        bus.address   = a;
        bus.writedata = d;
        #1;
        bw0   = bus.busywait;
        edges = 0;
        do begin
            @(posedge clock);
            #1;
            edges++;
        end while (bus.busywait && edges < 50);
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic test_reset;
        bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.writedata = '0;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busywait !== 1'b0) begin errors++; $display("FAIL reset_busywait got %b want 0", bus.busywait); end
        checks++;
        if (bus.readdata !== 128'h0) begin errors++; $display("FAIL reset_readdata got %h want 0", bus.readdata); end
        bus.read = 1'b1;
        #1;
        checks++;
        if (bus.busywait !== 1'b1) begin errors++; $display("FAIL reset_busywait_comb got %b want 1", bus.busywait); end
        bus.read = 1'b0;
        to_idle();
        reset = 1'b0;
        to_idle();
    endtask

    task automatic test_read_zero;
        int e; logic bw0;
        access(1'b1, 1'b0, 28'h0000005, '0, e, bw0);
        checks++;
        if (bw0 !== 1'b1) begin errors++; $display("FAIL rd0_busy_req got %b want 1", bw0); end
        checks++;
        if (e != 6) begin errors++; $display("FAIL rd0_latency got %0d want 6", e); end
        checks++;
        if (bus.readdata !== 128'h0) begin errors++; $display("FAIL rd0_data got %h want 0", bus.readdata); end
        to_idle();
    endtask

    task automatic test_write_read;
        int e; logic bw0;
        access(1'b0, 1'b1, 28'h12, D1, e, bw0);
        checks++;
        if (e != 6) begin errors++; $display("FAIL wr_latency got %0d want 6", e); end
        to_idle();
        access(1'b1, 1'b0, 28'h12, '0, e, bw0);
        checks++;
        if (e != 6) begin errors++; $display("FAIL rd_latency got %0d want 6", e); end
        checks++;
        if (bus.readdata !== D1) begin errors++; $display("FAIL wr_rd_data got %h want %h", bus.readdata, D1); end
        to_idle();
    endtask

    task automatic test_done_bubble;
        int e; logic bw0;
        access(1'b0, 1'b1, 28'h7, D2, e, bw0);
        // New request arriving in DONE must be ignored for that cycle.
        bus.read    = 1'b1;
        bus.address = 28'h7;
        #1;
        checks++;
        if (bus.busywait !== 1'b0) begin errors++; $display("FAIL done_busywait got %b want 0", bus.busywait); end
        to_idle();
        checks++;
        if (bus.busywait !== 1'b1) begin errors++; $display("FAIL bubble_rerise got %b want 1", bus.busywait); end
        access(1'b1, 1'b0, 28'h7, '0, e, bw0);
        checks++;
        if (e != 6) begin errors++; $display("FAIL bubble_latency got %0d want 6", e); end
        checks++;
        if (bus.readdata !== D2) begin errors++; $display("FAIL bubble_data got %h want %h", bus.readdata, D2); end
        to_idle();
    endtask

    task automatic test_alias;
        int e; logic bw0;
        access(1'b0, 1'b1, 28'h112, D3, e, bw0);
        checks++;
        if (bus.readdata !== D2) begin errors++; $display("FAIL alias_wr_keeps_rd got %h want %h", bus.readdata, D2); end
        to_idle();
        access(1'b1, 1'b0, 28'h12, '0, e, bw0);
        checks++;
        if (bus.readdata !== D3) begin errors++; $display("FAIL alias_data got %h want %h", bus.readdata, D3); end
        to_idle();
    endtask

    task automatic test_back_to_back;
        int e; logic bw0;
        access(1'b0, 1'b1, 28'h20, D4, e, bw0);
        to_idle();
        access(1'b0, 1'b1, 28'hA0, D5, e, bw0);
        to_idle();
        access(1'b1, 1'b0, 28'h20, '0, e, bw0);
        checks++;
        if (bw0 !== 1'b1) begin errors++; $display("FAIL b2b_rerise got %b want 1", bw0); end
        checks++;
        if (e != 6) begin errors++; $display("FAIL b2b_latency got %0d want 6", e); end
        checks++;
        if (bus.readdata !== D4) begin errors++; $display("FAIL b2b_refill got %h want %h", bus.readdata, D4); end
        to_idle();
        access(1'b1, 1'b0, 28'hA0, '0, e, bw0);
        checks++;
        if (bus.readdata !== D5) begin errors++; $display("FAIL b2b_writeback got %h want %h", bus.readdata, D5); end
        to_idle();
    endtask

    task automatic test_reset_mid;
        int e; logic bw0;
        bus.write = 1'b1; bus.address = 28'h33; bus.writedata = D6;
        to_idle();
        to_idle();
        to_idle();
        reset = 1'b1;
        bus.write = 1'b0;
        #1;
        checks++;
        if (bus.busywait !== 1'b0) begin errors++; $display("FAIL rst_mid_busywait got %b want 0", bus.busywait); end
        checks++;
        if (bus.readdata !== 128'h0) begin errors++; $display("FAIL rst_mid_readdata got %h want 0", bus.readdata); end
        to_idle();
        reset = 1'b0;
        to_idle();
        access(1'b1, 1'b0, 28'h33, '0, e, bw0);
        checks++;
        if (bus.readdata !== 128'h0) begin errors++; $display("FAIL rst_mid_no_commit got %h want 0", bus.readdata); end
        to_idle();
    endtask

    task automatic test_rw_both;
        int e; logic bw0;
        access(1'b1, 1'b1, 28'h40, D2, e, bw0);
        checks++;
        if (bus.readdata !== 128'h0) begin errors++; $display("FAIL rw_keeps_rd got %h want 0", bus.readdata); end
        to_idle();
        access(1'b1, 1'b0, 28'h40, '0, e, bw0);
        checks++;
        if (bus.readdata !== D2) begin errors++; $display("FAIL rw_is_write got %h want %h", bus.readdata, D2); end
        to_idle();
    endtask

`ifdef BLOCK_MEMORY_PERF_EN
    task automatic test_perf;
        int e; logic bw0;
        reset = 1'b1;
        to_idle();
        reset = 1'b0;
        to_idle();
        for (int i = 1; i <= 3; i++) begin
            access(1'b0, 1'b1, 28'(i), D1, e, bw0);
            to_idle();
        end
        for (int i = 1; i <= 2; i++) begin
            access(1'b1, 1'b0, 28'(i), '0, e, bw0);
            to_idle();
        end
        access(1'b1, 1'b1, 28'h9, D3, e, bw0);
        to_idle();
        checks++;
        if (wr_count !== 32'd4) begin errors++; $display("FAIL perf_wr got %0d want 4", wr_count); end
        checks++;
        if (rd_count !== 32'd2) begin errors++; $display("FAIL perf_rd got %0d want 2", rd_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_read_zero();
        test_write_read();
        test_done_bubble();
        test_alias();
        test_back_to_back();
        test_reset_mid();
        test_rw_both();
`ifdef BLOCK_MEMORY_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
